// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control unit: FSM
//            states, opcode/funct codes, ALU op codes and mux selects.
// Revision : 1.0  initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REXEC  = 4'd6,
    ST_RWB    = 4'd7,
    ST_BEQ    = 4'd8,
    ST_BNE    = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_SLT = 6'b101010;
  localparam logic [5:0] C_FN_NOR = 6'b100111;

  // ALU operation codes, shared with the ALU itself
  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;

  // ALU B-operand select
  localparam logic [1:0] C_SRCB_B      = 2'd0;
  localparam logic [1:0] C_SRCB_FOUR   = 2'd1;
  localparam logic [1:0] C_SRCB_IMM    = 2'd2;
  localparam logic [1:0] C_SRCB_IMM_SH = 2'd3;

  // PC source select
  localparam logic [1:0] C_PCSRC_ALU    = 2'd0;
  localparam logic [1:0] C_PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] C_PCSRC_JUMP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ============================================================================
// Module   : alu_control
// Purpose  : Combinational R-type funct -> ALU op decode with an
//            unsupported-funct flag. Unknown functs fall back to add.
// Revision : 1.0  initial release
// ============================================================================
module alu_control (
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       unsupported
);
  import mc_pkg::*;

  // Map funct to ALU op; anything outside the supported set is flagged
  always_comb begin
    alu_op      = C_ALU_ADD;
    unsupported = 1'b0;
    case (funct)
      C_FN_AND: alu_op = C_ALU_AND;
      C_FN_OR:  alu_op = C_ALU_OR;
      C_FN_ADD: alu_op = C_ALU_ADD;
      C_FN_SUB: alu_op = C_ALU_SUB;
      C_FN_SLT: alu_op = C_ALU_SLT;
      C_FN_NOR: alu_op = C_ALU_NOR;
      default:  unsupported = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/
//            memory/write-back, drives datapath selects and strobes, flags
//            unsupported instructions and counts retired instructions.
// Revision : 1.0  initial release
// ============================================================================
module mc_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic [31:0] instr_count
);
  import mc_pkg::*;

  state_t      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [3:0]  w_fn_alu_op;
  logic        w_fn_bad;
  logic        w_op_bad;
  logic        w_retire;

  alu_control u_alu_control (
    .funct       (funct),
    .alu_op      (w_fn_alu_op),
    .unsupported (w_fn_bad)
  );

  // Opcode legality check used in DECODE
  always_comb begin
    case (opcode)
      C_OP_RTYPE, C_OP_LW, C_OP_SW, C_OP_BEQ,
      C_OP_BNE, C_OP_ADDI, C_OP_J: w_op_bad = 1'b0;
      default:                     w_op_bad = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          C_OP_RTYPE:      state_d = ST_REXEC;
          C_OP_LW, C_OP_SW: state_d = ST_MEMADR;
          C_OP_BEQ:        state_d = ST_BEQ;
          C_OP_BNE:        state_d = ST_BNE;
          C_OP_ADDI:       state_d = ST_ADDIEX;
          C_OP_J:          state_d = ST_JUMP;
          default:         state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opcode == C_OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_REXEC:  state_d = w_fn_bad ? ST_FETCH : ST_RWB;
      ST_ADDIEX: state_d = ST_ADDIWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Retire counter: the final state of every legal instruction returns to FETCH
  always_comb begin
    case (state_q)
      ST_MEMWB, ST_MEMWR, ST_RWB, ST_BEQ,
      ST_BNE, ST_JUMP, ST_ADDIWB: w_retire = 1'b1;
      default:                    w_retire = 1'b0;
    endcase
    instr_count_d = instr_count_q + {31'd0, w_retire};
  end

  // State and counter registers; reset aborts any instruction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Moore output decode; pc_en, REXEC alu_op and illegal also look at inputs
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = C_SRCB_B;
    alu_op     = C_ALU_AND;
    pc_src     = C_PCSRC_ALU;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = C_SRCB_FOUR;
        alu_op    = C_ALU_ADD;
        pc_en     = 1'b1;
      end
      ST_DECODE: begin
        alu_src_b = C_SRCB_IMM_SH;
        alu_op    = C_ALU_ADD;
        illegal   = w_op_bad;
      end
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = C_SRCB_IMM;
        alu_op    = C_ALU_ADD;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_ADDIWB: reg_write = 1'b1;
      ST_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = w_fn_alu_op;
        illegal   = w_fn_bad;
      end
      ST_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = C_ALU_SUB;
        pc_src    = C_PCSRC_ALUOUT;
        pc_en     = (state_q == ST_BEQ) ? zero : ~zero;
      end
      ST_JUMP: begin
        pc_src = C_PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Self-checking bench for mc_control. An instruction-level model
//            predicts the output bundle for each cycle of an instruction and
//            the retired-instruction count.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        zero = 1'b0;
  logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic        reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_op;
  logic [31:0] instr_count;

  mc_control dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .pc_en       (pc_en),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Output bundle: pc_en iord mem_read mem_write ir_write mem_to_reg reg_dst
  //                reg_write alu_src_a alu_src_b[2] alu_op[4] pc_src[2] illegal
  logic [17:0] act_vec;
  assign act_vec = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,
                    reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

  int          n_checks = 0;
  int          n_fail = 0;
  bit          exp_valid = 1'b0;
  logic [17:0] exp_vec = '0;
  logic [31:0] exp_count = '0;
  string       cur_name = "reset";
  int          cur_step = 0;

  function automatic logic [17:0] mk(input logic pe, input logic io, input logic mr,
                                     input logic mw, input logic irw, input logic m2r,
                                     input logic rd, input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic [3:0] op,
                                     input logic [1:0] ps, input logic ill);
    return {pe, io, mr, mw, irw, m2r, rd, rw, asa, asb, op, ps, ill};
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  // {supported, alu code} for an R-type funct
  function automatic logic [4:0] fn_decode(input logic [5:0] fn);
    case (fn)
      6'h24:   return 5'b1_0000;
      6'h25:   return 5'b1_0001;
      6'h20:   return 5'b1_0010;
      6'h22:   return 5'b1_0110;
      6'h2a:   return 5'b1_0111;
      6'h27:   return 5'b1_1100;
      default: return 5'b0_0010;
    endcase
  endfunction

  // Cycles from FETCH until FETCH is entered again
  function automatic int instr_len(input logic [5:0] op, input logic [5:0] fn);
    logic [4:0] d;
    d = fn_decode(fn);
    if (!op_known(op)) return 2;
    case (op)
      6'h00:        return d[4] ? 4 : 3;
      6'h23:        return 5;
      6'h2b, 6'h08: return 4;
      default:      return 3;
    endcase
  endfunction

  function automatic bit retires(input logic [5:0] op, input logic [5:0] fn);
    logic [4:0] d;
    d = fn_decode(fn);
    return op_known(op) && (op != 6'h00 || d[4]);
  endfunction

  // Expected output bundle for cycle 'step' of an instruction
  function automatic logic [17:0] expect_vec(input logic [5:0] op, input logic [5:0] fn,
                                             input logic z, input int step);
    logic [4:0] d;
    d = fn_decode(fn);
    if (step == 0) return mk(1,0,1,0,1,0,0,0,0, 2'd1, 4'b0010, 2'd0, 0);
    if (step == 1) return mk(0,0,0,0,0,0,0,0,0, 2'd3, 4'b0010, 2'd0, !op_known(op));
    case (op)
      6'h00: begin
        if (step == 2) return mk(0,0,0,0,0,0,0,0,1, 2'd0, d[3:0], 2'd0, !d[4]);
        return mk(0,0,0,0,0,0,1,1,0, 2'd0, 4'b0000, 2'd0, 0);
      end
      6'h23: begin
        if (step == 2) return mk(0,0,0,0,0,0,0,0,1, 2'd2, 4'b0010, 2'd0, 0);
        if (step == 3) return mk(0,1,1,0,0,0,0,0,0, 2'd0, 4'b0000, 2'd0, 0);
        return mk(0,0,0,0,0,1,0,1,0, 2'd0, 4'b0000, 2'd0, 0);
      end
      6'h2b: begin
        if (step == 2) return mk(0,0,0,0,0,0,0,0,1, 2'd2, 4'b0010, 2'd0, 0);
        return mk(0,1,0,1,0,0,0,0,0, 2'd0, 4'b0000, 2'd0, 0);
      end
      6'h08: begin
        if (step == 2) return mk(0,0,0,0,0,0,0,0,1, 2'd2, 4'b0010, 2'd0, 0);
        return mk(0,0,0,0,0,0,0,1,0, 2'd0, 4'b0000, 2'd0, 0);
      end
      6'h04:   return mk(z,0,0,0,0,0,0,0,1, 2'd0, 4'b0110, 2'd1, 0);
      6'h05:   return mk(!z,0,0,0,0,0,0,0,1, 2'd0, 4'b0110, 2'd1, 0);
      6'h02:   return mk(1,0,0,0,0,0,0,0,0, 2'd0, 4'b0000, 2'd2, 0);
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clock) begin
    if (exp_valid) begin
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL %s step %0d outputs: got %b required %b", cur_name, cur_step, act_vec, exp_vec);
      end
      n_checks++;
      if (instr_count !== exp_count) begin
        n_fail++;
        $display("FAIL %s step %0d instr_count: got %0d required %0d", cur_name, cur_step, instr_count, exp_count);
      end
    end
  end

  // Run one instruction from FETCH; optionally pin one step to a literal bundle
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int probe_step, input logic [17:0] probe_vec);
    int len;
    len = instr_len(op, fn);
    cur_name = name;
    opcode = op;
    funct = fn;
    zero = z;
    exp_valid = 1'b1;
    for (int s = 0; s < len; s++) begin
      cur_step = s;
      exp_vec = expect_vec(op, fn, z, s);
      if (s == probe_step) begin
        #2;
        check({name, " literal"}, {14'd0, act_vec}, {14'd0, probe_vec});
      end
      @(posedge clock);
      #1;
    end
    if (retires(op, fn)) exp_count = exp_count + 32'd1;
    cur_step = 0;
    exp_vec = expect_vec(op, fn, z, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    // Reset held low: FETCH outputs, illegal 0 even with a bad opcode present
    opcode = 6'h3f;
    exp_vec = expect_vec(6'h00, 6'h20, 1'b0, 0);
    exp_count = 32'd0;
    exp_valid = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    check("reset pc_en", {31'd0, pc_en}, 32'd1);
    check("reset ir_write", {31'd0, ir_write}, 32'd1);
    check("reset illegal", {31'd0, illegal}, 32'd0);
    check("reset instr_count", instr_count, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    run_instr("sub decode", 6'h00, 6'h22, 1'b0, 1, 18'b00000000_0_11_0010_00_0);
    check("sub retired", instr_count, 32'd1);
    run_instr("sub rexec", 6'h00, 6'h22, 1'b0, 2, 18'b00000000_1_00_0110_00_0);
    run_instr("sub rwb", 6'h00, 6'h22, 1'b0, 3, 18'b000000_1_1_0_00_0000_00_0);
    run_instr("lw memrd", 6'h23, 6'h00, 1'b0, 3, 18'b0_1_1_000000_00_0000_00_0);
    run_instr("lw memwb", 6'h23, 6'h00, 1'b0, 4, 18'b00000_1_0_1_0_00_0000_00_0);
    check("after lw count", instr_count, 32'd5);
    run_instr("sw", 6'h2b, 6'h00, 1'b0, -1, '0);
    run_instr("addi", 6'h08, 6'h00, 1'b1, -1, '0);
    run_instr("beq z1", 6'h04, 6'h00, 1'b1, 2, 18'b1_0000000_1_00_0110_01_0);
    run_instr("beq z0", 6'h04, 6'h00, 1'b0, -1, '0);
    run_instr("bne z1", 6'h05, 6'h00, 1'b1, 2, 18'b0_0000000_1_00_0110_01_0);
    run_instr("bne z0", 6'h05, 6'h00, 1'b0, -1, '0);
    run_instr("j", 6'h02, 6'h00, 1'b0, -1, '0);
    run_instr("and", 6'h00, 6'h24, 1'b0, -1, '0);
    run_instr("or", 6'h00, 6'h25, 1'b0, -1, '0);
    run_instr("add", 6'h00, 6'h20, 1'b0, -1, '0);
    run_instr("slt", 6'h00, 6'h2a, 1'b0, -1, '0);
    run_instr("nor", 6'h00, 6'h27, 1'b0, -1, '0);
    check("count before illegal", instr_count, 32'd17);
    run_instr("bad opcode", 6'h3f, 6'h00, 1'b0, 1, 18'b00000000_0_11_0010_00_1);
    run_instr("bad funct", 6'h00, 6'h07, 1'b0, 2, 18'b00000000_1_00_0010_00_1);
    check("count after illegal", instr_count, 32'd17);

    // Reset asserted inside RWB aborts the write-back at once
    cur_name = "abort rwb";
    opcode = 6'h00;
    funct = 6'h20;
    for (int s = 0; s < 3; s++) begin
      cur_step = s;
      exp_vec = expect_vec(6'h00, 6'h20, 1'b0, s);
      @(posedge clock);
      #1;
    end
    cur_step = 3;
    exp_vec = expect_vec(6'h00, 6'h20, 1'b0, 3);
    #1;
    check("rwb before reset reg_write", {31'd0, reg_write}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort reg_write", {31'd0, reg_write}, 32'd0);
    check("abort fetch outputs", {14'd0, act_vec}, {14'd0, 18'b101010000_01_0010_00_0});
    check("abort state", {28'd0, dut.state_q}, 32'd0);
    exp_count = 32'd0;
    cur_step = 0;
    exp_vec = expect_vec(6'h00, 6'h20, 1'b0, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Counter wrap from all-ones
    run_instr("addi after reset", 6'h08, 6'h00, 1'b0, -1, '0);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr("j wrap", 6'h02, 6'h00, 1'b0, -1, '0);
    check("wrap count", instr_count, 32'd0);
    run_instr("lw after wrap", 6'h23, 6'h00, 1'b0, -1, '0);
    check("post-wrap count", instr_count, 32'd1);

    @(negedge clock);
    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
